display_refresh_sequencer: RTL and testbench

Sequences one refresh frame of the clock's serial LED display path. On request, it snapshots the BCD time digits and the PM flag and converts each digit to a 7-segment byte. It then shifts the bytes out on `serial_out`/`clk_out` and pulses `latch_out`. It sits between the timekeeping/BCD logic and the top-level serial pins (`serial_out`, `clk_out`, `latch_out`), and owns all frame timing for the external shift-register chain.

---
 rtl/display_refresh_sequencer.sv | 166 ++++++++++++++++
 tb/tb_display_refresh_sequencer.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/display_refresh_sequencer.sv
// Serial 7-segment refresh sequencer: snapshots BCD digits + PM flag, shifts a frame MSB-first, then latches.
// Optional DISPLAY_LEADING_ZERO_BLANK_EN blanks a zero in the most significant digit.
module display_refresh_sequencer #(
  parameter int unsigned NUM_DIGITS = 4,
  parameter int unsigned CLK_DIV    = 2
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    refresh_req,
  input  logic [4*NUM_DIGITS-1:0] digits,
  input  logic                    pm_in,
  output logic                    serial_out,
  output logic                    clk_out,
  output logic                    latch_out,
  output logic                    busy,
  output logic                    done
);

  localparam int unsigned FRAME_BITS = 8 * NUM_DIGITS;
  localparam int unsigned DIV_W      = $clog2(CLK_DIV + 1);
  localparam int unsigned BIT_W      = $clog2(FRAME_BITS + 1);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [BIT_W-1:0] BIT_LOAD = BIT_W'(FRAME_BITS);
  localparam logic [BIT_W-1:0] BIT_ONE  = BIT_W'(1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_SHIFT_LO,
    ST_SHIFT_HI,
    ST_LATCH
  } state_e;

  state_e                    state_q, state_d;
  logic [DIV_W-1:0]          div_q, div_d;
  logic [BIT_W-1:0]          bit_q, bit_d;
  logic [FRAME_BITS-1:0]     shreg_q, shreg_d;
  logic [4*NUM_DIGITS-1:0]   snap_digits_q, snap_digits_d;
  logic                      snap_pm_q, snap_pm_d;
  logic                      pending_q, pending_d;
  logic                      done_q, done_d;
  logic                      div_last;
  logic                      start;
  logic [FRAME_BITS-1:0]     frame;

  function automatic logic [7:0] seg7(input logic [3:0] d);
    case (d)
      4'd0:    seg7 = 8'hFC;
      4'd1:    seg7 = 8'h60;
      4'd2:    seg7 = 8'hDA;
      4'd3:    seg7 = 8'hF2;
      4'd4:    seg7 = 8'h66;
      4'd5:    seg7 = 8'hB6;
      4'd6:    seg7 = 8'hBE;
      4'd7:    seg7 = 8'hE0;
      4'd8:    seg7 = 8'hFE;
      4'd9:    seg7 = 8'hF6;
      default: seg7 = 8'h02;
    endcase
  endfunction

  assign div_last = (div_q == DIV_LAST);
  assign start    = (state_q == ST_IDLE) && (refresh_req || pending_q);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:     if (refresh_req || pending_q) state_d = ST_LOAD;
      ST_LOAD:     state_d = ST_SHIFT_LO;
      ST_SHIFT_LO: if (div_last) state_d = ST_SHIFT_HI;
      ST_SHIFT_HI: if (div_last) state_d = (bit_q == BIT_ONE) ? ST_LATCH : ST_SHIFT_LO;
      ST_LATCH:    if (div_last) state_d = ST_IDLE;
      default:     state_d = ST_IDLE;
    endcase
  end

  // Digit NUM_DIGITS-1 occupies the top byte so it leaves first; PM rides on digit 0's dp.
  always_comb begin
    frame = '0;
    for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
      frame[8*i +: 8] = seg7(snap_digits_q[4*i +: 4]);
    end
`ifdef DISPLAY_LEADING_ZERO_BLANK_EN
    if (snap_digits_q[4*(NUM_DIGITS-1) +: 4] == 4'd0) begin
      frame[FRAME_BITS-1 -: 8] = 8'h00;
    end
`endif
    frame[0] = snap_pm_q;
  end

  always_comb begin
    div_d         = '0;
    bit_d         = bit_q;
    shreg_d       = shreg_q;
    snap_digits_d = snap_digits_q;
    snap_pm_d     = snap_pm_q;
    pending_d     = pending_q;
    done_d        = (state_q == ST_LATCH) && div_last;
    if (state_q == ST_SHIFT_LO || state_q == ST_SHIFT_HI || state_q == ST_LATCH) begin
      div_d = div_last ? '0 : div_q + 1'b1;
    end
    if (state_q == ST_IDLE) begin
      if (start) begin
        snap_digits_d = digits;
        snap_pm_d     = pm_in;
        pending_d     = 1'b0;
      end
    end else begin
      pending_d = pending_q | refresh_req;
    end
    if (state_q == ST_LOAD) begin
      shreg_d = frame;
      bit_d   = BIT_LOAD;
    end
    if (state_q == ST_SHIFT_HI && div_last) begin
      shreg_d = shreg_q << 1;
      bit_d   = bit_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      div_q         <= '0;
      bit_q         <= '0;
      shreg_q       <= '0;
      snap_digits_q <= '0;
      snap_pm_q     <= 1'b0;
      pending_q     <= 1'b0;
      done_q        <= 1'b0;
    end else begin
      div_q         <= div_d;
      bit_q         <= bit_d;
      shreg_q       <= shreg_d;
      snap_digits_q <= snap_digits_d;
      snap_pm_q     <= snap_pm_d;
      pending_q     <= pending_d;
      done_q        <= done_d;
    end
  end

  always_comb begin
    serial_out = 1'b0;
    clk_out    = 1'b0;
    latch_out  = 1'b0;
    busy       = (state_q != ST_IDLE);
    done       = done_q;
    case (state_q)
      ST_SHIFT_LO: serial_out = shreg_q[FRAME_BITS-1];
      ST_SHIFT_HI: begin
        serial_out = shreg_q[FRAME_BITS-1];
        clk_out    = 1'b1;
      end
      ST_LATCH:    latch_out = 1'b1;
      default:     ;
    endcase
  end

endmodule

// File: tb/tb_display_refresh_sequencer.sv
// Directed self-checking bench for display_refresh_sequencer (NUM_DIGITS=4, CLK_DIV=2).
module tb_display_refresh_sequencer;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        refresh_req = 1'b0;
  logic [15:0] digits = '0;
  logic        pm_in = 1'b0;
  logic        serial_out, clk_out, latch_out, busy, done;

  int compared = 0;
  int mismatched = 0;

  display_refresh_sequencer #(.NUM_DIGITS(4), .CLK_DIV(2)) dut (
    .clk(clk), .reset(reset), .refresh_req(refresh_req), .digits(digits), .pm_in(pm_in),
    .serial_out(serial_out), .clk_out(clk_out), .latch_out(latch_out), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  // Output monitor, sampled on the falling edge.
  logic [31:0] frame_bits = '0;
  int rises = 0, done_cnt = 0, latch_cnt = 0, busy_cnt = 0, frames = 0, done_after_busy = 0;
  int busy_run = 0, last_busy_run = 0, gap_run = 0, last_gap = 0;
  int ser_stable = 0, since_rise = 0, min_setup = 99, min_hold = 99;
  logic prev_clk_out = 1'b0, prev_serial = 1'b0, prev_busy = 1'b0, rise_seen = 1'b0;

  always @(negedge clk) begin
    since_rise++;
    if (serial_out !== prev_serial) begin
      if (rise_seen && !reset && since_rise < min_hold) min_hold = since_rise;
      ser_stable = 0;
    end else begin
      ser_stable++;
    end
    if (!prev_clk_out && clk_out) begin
      frame_bits = {frame_bits[30:0], serial_out};
      rises++;
      if (ser_stable < min_setup) min_setup = ser_stable;
      since_rise = 0;
      rise_seen = 1'b1;
    end
    if (busy) begin
      busy_run++;
      busy_cnt++;
      if (!prev_busy) begin
        last_gap = gap_run;
        frames++;
      end
      gap_run = 0;
    end else begin
      if (prev_busy) last_busy_run = busy_run;
      busy_run = 0;
      gap_run++;
      rise_seen = 1'b0;
    end
    if (done) begin
      done_cnt++;
      if (prev_busy && !busy) done_after_busy++;
    end
    if (latch_out) latch_cnt++;
    prev_clk_out = clk_out;
    prev_serial  = serial_out;
    prev_busy    = busy;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_done(input int bound, input string name);
    int n;
    n = 0;
    while (done !== 1'b1 && n < bound) begin
      tick();
      n++;
    end
    compared++;
    if (done !== 1'b1) begin
      mismatched++;
      $display("FAIL %s: done not seen within %0d cycles (got done=%b, want 1)", name, bound, done);
    end
    repeat (3) tick();
  endtask

  task automatic test_reset();
    int bad;
    reset = 1'b1;
    tick();
    tick();
    compared++; if (serial_out !== 1'b0) begin mismatched++; $display("FAIL reset_serial: got %b want 0", serial_out); end
    compared++; if (clk_out !== 1'b0) begin mismatched++; $display("FAIL reset_clk_out: got %b want 0", clk_out); end
    compared++; if (latch_out !== 1'b0) begin mismatched++; $display("FAIL reset_latch: got %b want 0", latch_out); end
    compared++; if (busy !== 1'b0) begin mismatched++; $display("FAIL reset_busy: got %b want 0", busy); end
    compared++; if (done !== 1'b0) begin mismatched++; $display("FAIL reset_done: got %b want 0", done); end
    reset = 1'b0;
    bad = 0;
    for (int i = 0; i < 50; i++) begin
      tick();
      if ({serial_out, clk_out, latch_out, busy, done} !== 5'b0) bad++;
    end
    compared++;
    if (bad !== 0) begin mismatched++; $display("FAIL idle_quiet: got %0d active cycles want 0", bad); end
  endtask

  task automatic test_single_frame();
    int d0, l0, r0, da0;
    digits = 16'h1234;
    pm_in  = 1'b1;
    d0 = done_cnt; l0 = latch_cnt; r0 = rises; da0 = done_after_busy;
    refresh_req = 1'b1;
    tick();
    refresh_req = 1'b0;
    compared++; if (busy !== 1'b1) begin mismatched++; $display("FAIL start_busy: got %b want 1", busy); end
    tick();
    compared++; if (clk_out !== 1'b0) begin mismatched++; $display("FAIL first_lo: got %b want 0", clk_out); end
    tick();
    compared++; if (clk_out !== 1'b0) begin mismatched++; $display("FAIL second_lo: got %b want 0", clk_out); end
    tick();
    compared++; if (clk_out !== 1'b1) begin mismatched++; $display("FAIL first_rise: got %b want 1", clk_out); end
    wait_done(400, "single_done");
    compared++; if (frame_bits !== 32'h60DAF267) begin mismatched++; $display("FAIL single_bytes: got %h want 60daf267", frame_bits); end
    compared++; if (last_busy_run !== 131) begin mismatched++; $display("FAIL single_busy_len: got %0d want 131", last_busy_run); end
    compared++; if (latch_cnt - l0 !== 2) begin mismatched++; $display("FAIL single_latch_len: got %0d want 2", latch_cnt - l0); end
    compared++; if (done_cnt - d0 !== 1) begin mismatched++; $display("FAIL single_done_cnt: got %0d want 1", done_cnt - d0); end
    compared++; if (done_after_busy - da0 !== 1) begin mismatched++; $display("FAIL single_done_pos: got %0d want 1", done_after_busy - da0); end
    compared++; if (rises - r0 !== 32) begin mismatched++; $display("FAIL single_rises: got %0d want 32", rises - r0); end
    compared++; if (min_setup < 2) begin mismatched++; $display("FAIL setup: got %0d want >=2", min_setup); end
    compared++; if (min_hold < 2) begin mismatched++; $display("FAIL hold: got %0d want >=2", min_hold); end
  endtask

  task automatic test_invalid_snapshot();
    int r0;
    digits = 16'hA000;
    pm_in  = 1'b0;
    r0 = rises;
    refresh_req = 1'b1;
    tick();
    refresh_req = 1'b0;
    digits = 16'h1111;
    pm_in  = 1'b1;
    wait_done(400, "snapshot_done");
    compared++; if (frame_bits !== 32'h02FCFCFC) begin mismatched++; $display("FAIL snapshot_bytes: got %h want 02fcfcfc", frame_bits); end
    compared++; if (rises - r0 !== 32) begin mismatched++; $display("FAIL snapshot_rises: got %0d want 32", rises - r0); end
  endtask

  task automatic test_coalescing();
    int d0, f0, n;
    digits = 16'h5678;
    pm_in  = 1'b0;
    d0 = done_cnt; f0 = frames;
    refresh_req = 1'b1;
    tick();
    refresh_req = 1'b0;
    for (int k = 0; k < 3; k++) begin
      repeat (20) tick();
      refresh_req = 1'b1;
      tick();
      refresh_req = 1'b0;
    end
    n = 0;
    while (latch_out !== 1'b1 && n < 300) begin tick(); n++; end
    tick();
    compared++;
    if (latch_out !== 1'b1) begin mismatched++; $display("FAIL coalesce_latch: got %b want 1", latch_out); end
    refresh_req = 1'b1;
    tick();
    refresh_req = 1'b0;
    compared++; if (done !== 1'b1) begin mismatched++; $display("FAIL coalesce_done1: got %b want 1", done); end
    compared++; if (busy !== 1'b0) begin mismatched++; $display("FAIL coalesce_gap: got %b want 0", busy); end
    tick();
    compared++; if (busy !== 1'b1) begin mismatched++; $display("FAIL coalesce_restart: got %b want 1", busy); end
    wait_done(400, "coalesce_done2");
    repeat (300) tick();
    compared++; if (done_cnt - d0 !== 2) begin mismatched++; $display("FAIL coalesce_dones: got %0d want 2", done_cnt - d0); end
    compared++; if (frames - f0 !== 2) begin mismatched++; $display("FAIL coalesce_frames: got %0d want 2", frames - f0); end
    compared++; if (last_gap !== 1) begin mismatched++; $display("FAIL coalesce_gap_len: got %0d want 1", last_gap); end
    compared++; if (frame_bits !== 32'hB6BEE0FE) begin mismatched++; $display("FAIL coalesce_bytes: got %h want b6bee0fe", frame_bits); end
  endtask

  task automatic test_reset_mid_frame();
    int d0, l0, f0, r0, n;
    digits = 16'h1234;
    pm_in  = 1'b0;
    d0 = done_cnt; l0 = latch_cnt; f0 = frames; r0 = rises;
    refresh_req = 1'b1;
    tick();
    refresh_req = 1'b0;
    repeat (5) tick();
    refresh_req = 1'b1;
    tick();
    refresh_req = 1'b0;
    n = 0;
    while (rises - r0 < 13 && n < 300) begin tick(); n++; end
    compared++;
    if (rises - r0 !== 13) begin mismatched++; $display("FAIL midreset_reach: got %0d rises want 13", rises - r0); end
    reset = 1'b1;
    tick();
    compared++;
    if ({serial_out, clk_out, latch_out, busy, done} !== 5'b0) begin
      mismatched++; $display("FAIL midreset_outputs: got %b want 00000", {serial_out, clk_out, latch_out, busy, done});
    end
    reset = 1'b0;
    repeat (300) tick();
    compared++; if (latch_cnt - l0 !== 0) begin mismatched++; $display("FAIL midreset_latch: got %0d want 0", latch_cnt - l0); end
    compared++; if (done_cnt - d0 !== 0) begin mismatched++; $display("FAIL midreset_done: got %0d want 0", done_cnt - d0); end
    compared++; if (frames - f0 !== 1) begin mismatched++; $display("FAIL midreset_restart: got %0d frames want 1", frames - f0); end
  endtask

  task automatic test_leading_zero();
    logic [31:0] want;
`ifdef DISPLAY_LEADING_ZERO_BLANK_EN
    want = 32'h00F6FCB6;
`else
    want = 32'hFCF6FCB6;
`endif
    digits = 16'h0905;
    pm_in  = 1'b0;
    refresh_req = 1'b1;
    tick();
    refresh_req = 1'b0;
    wait_done(400, "lz_done");
    compared++; if (frame_bits !== want) begin mismatched++; $display("FAIL lz_bytes: got %h want %h", frame_bits, want); end
  endtask

  initial begin
    test_reset();
    test_single_frame();
    test_invalid_snapshot();
    test_coalescing();
    test_reset_mid_frame();
    test_leading_zero();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
